// File: rtl/irq_arbiter_if.sv
// -----------------------------------------------------------------------------
// irq_arbiter_if
// Bundle of the interrupt request sources and the Controller handshake used by
// irq_arbiter.
//
// Parameters:
//   N_IRQ : number of maskable channels (1..32)
//   ID_W  : width of IrqId (>= ceil(log2(N_IRQ)), >= 1)
//
// Signals (driven by master, sampled by slave unless noted):
//   IrqIn[N_IRQ]    request lines, bit 0 highest priority
//   EdgeMode[N_IRQ] 1 = rising-edge channel, 0 = level channel
//   IrqMask[N_IRQ]  1 = channel masked
//   NMI             non-maskable request (always rising-edge detected)
//   INTD            global disable of the maskable channels
//   INA             acknowledge pulse from the Controller
//   EOI             end-of-interrupt pulse
//   INT             (slave out) request to the Controller
//   isInterrupted   (slave out) an interrupt is in service
//   IrqId[ID_W]     (slave out) winning / in-service channel, 0 for NMI
//   IsNmi           (slave out) winner / in-service source is NMI
//   Pending[N_IRQ]  (slave out) registered pending bits, unmasked view
//
// Modports:
//   master : the side that owns the request lines and the Controller
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface irq_arbiter_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] IrqIn;
    logic [N_IRQ-1:0] EdgeMode;
    logic [N_IRQ-1:0] IrqMask;
    logic             NMI;
    logic             INTD;
    logic             INA;
    logic             EOI;
    logic             INT;
    logic             isInterrupted;
    logic [ID_W-1:0]  IrqId;
    logic             IsNmi;
    logic [N_IRQ-1:0] Pending;

    modport master (
        output IrqIn, EdgeMode, IrqMask, NMI, INTD, INA, EOI,
        input  INT, isInterrupted, IrqId, IsNmi, Pending
    );

    modport slave (
        input  IrqIn, EdgeMode, IrqMask, NMI, INTD, INA, EOI,
        output INT, isInterrupted, IrqId, IsNmi, Pending
    );
endinterface

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Interrupt front-end for the multicycle MIPS core. Collects N_IRQ maskable
// request lines plus one NMI, keeps them pending, selects a winner by fixed
// priority (NMI first, then lowest channel index), raises a single INT to the
// Controller and tracks the in-service interrupt until EOI. No nesting.
//
// Ports:
//   Clk      : single clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : irq_arbiter_if.slave (request lines, mask/disable, INA/EOI
//              handshake in; INT, isInterrupted, IrqId, IsNmi, Pending out)
//
// Build option:
//   IRQ_EDGE_DETECT_EN defined   -> per-channel edge/level select via EdgeMode,
//                                   with a previous-sample register per channel.
//   IRQ_EDGE_DETECT_EN undefined -> every maskable channel is level-sensitive
//                                   and EdgeMode is ignored.
//   NMI is rising-edge detected in both builds.
// -----------------------------------------------------------------------------
module irq_arbiter #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic          Clk,
    input  logic          Reset_n,
    irq_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [N_IRQ-1:0] pend_reg, pend_next;
    logic [N_IRQ-1:0] eligible;
    logic             nmi_prev_reg;
    logic             nmi_pend_reg, nmi_pend_next;
    logic             nmi_rise;
    logic [ID_W-1:0]  id_reg, id_next;
    logic             is_nmi_reg, is_nmi_next;
    logic [ID_W-1:0]  win_id;
    logic             cand;
    logic             ack_fire;

    // An acknowledge only counts while a request is actually being shown.
    assign ack_fire = (state_reg == REQ) && bus.INA;

    // ---------------------------------------------------------------- NMI latch
    assign nmi_rise = bus.NMI & ~nmi_prev_reg;
    // Set wins over a same-cycle clear.
    assign nmi_pend_next = nmi_rise | (nmi_pend_reg & ~(ack_fire & is_nmi_reg));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nmi_prev_reg <= 1'b0;
            nmi_pend_reg <= 1'b0;
        end else begin
            nmi_prev_reg <= bus.NMI;
            nmi_pend_reg <= nmi_pend_next;
        end
    end

    // ------------------------------------------------------ per-channel pending
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_ch
`ifdef IRQ_EDGE_DETECT_EN
            logic prev_reg;
            logic ack_ch;

            // Acknowledge targets the registered winner, i.e. the value the
            // Controller saw when it pulsed INA.
            assign ack_ch = ack_fire && !is_nmi_reg && (id_reg == ID_W'(gi));

            // Previous sample resets to 0 so a line already high at reset
            // release is seen as a rising edge.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= bus.IrqIn[gi];
                end
            end

            // Edge channel: set on rise, hold until acknowledged, set wins.
            // Level channel: just the registered line.
            assign pend_next[gi] = bus.EdgeMode[gi]
                                 ? ((bus.IrqIn[gi] & ~prev_reg) | (pend_reg[gi] & ~ack_ch))
                                 : bus.IrqIn[gi];
`else
            assign pend_next[gi] = bus.IrqIn[gi];
`endif
        end
    endgenerate

`ifndef IRQ_EDGE_DETECT_EN
    // EdgeMode has no meaning when every channel is level-sensitive.
    logic unused_edge_mode;
    assign unused_edge_mode = ^bus.EdgeMode;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // ------------------------------------------------------------- arbitration
    // Mask and INTD act combinationally so a change takes effect in the same
    // evaluation that registers the next winner/state.
    assign eligible = bus.INTD ? '0 : (pend_reg & ~bus.IrqMask);

    always_comb begin
        win_id = '0;
        if (!nmi_pend_reg) begin
            // Walk downward so the lowest eligible index is the last to write.
            for (int i = N_IRQ - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    win_id = ID_W'(i);
                end
            end
        end
    end

    assign cand = nmi_pend_reg | (|eligible);

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            id_reg     <= '0;
            is_nmi_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            id_reg     <= id_next;
            is_nmi_reg <= is_nmi_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        is_nmi_next = is_nmi_reg;
        case (state_reg)
            IDLE: begin
                if (cand) begin
                    id_next     = win_id;
                    is_nmi_next = nmi_pend_reg;
                    state_next  = REQ;
                end
            end
            REQ: begin
                // Acknowledge takes priority: the Controller has already
                // committed to the winner it saw, so keep it frozen.
                if (bus.INA) begin
                    state_next = SERVICE;
                end else if (cand) begin
                    id_next     = win_id;
                    is_nmi_next = nmi_pend_reg;
                end else begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (bus.EOI) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------------- outputs
    assign bus.INT           = (state_reg == REQ);
    assign bus.isInterrupted = (state_reg == SERVICE);
    assign bus.IrqId         = id_reg;
    assign bus.IsNmi         = is_nmi_reg;
    assign bus.Pending       = pend_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_arbiter
// Directed self-checking bench for irq_arbiter (N_IRQ=8, ID_W=3). Inputs are
// driven 1 time unit after the rising edge; outputs are checked at the same
// point, i.e. away from the active edge. Expectations are hand-computed per
// vector; the edge-channel vector picks its expectations from the
// IRQ_EDGE_DETECT_EN build option.
// -----------------------------------------------------------------------------
module tb_irq_arbiter;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    irq_arbiter_if #(.N_IRQ(N_IRQ), .ID_W(ID_W)) bus ();

    irq_arbiter #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IrqIn    = '0;
        bus.EdgeMode = '0;
        bus.IrqMask  = '0;
        bus.NMI      = 1'b0;
        bus.INTD     = 1'b0;
        bus.INA      = 1'b0;
        bus.EOI      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_ina();
        bus.INA = 1'b1;
        tick();
        bus.INA = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.EOI = 1'b1;
        tick();
        bus.EOI = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_inputs();

        // ---- 1: reset state, level request, ack, EOI with line still high
        do_reset();
        tick();
        check_value("rst_int",     32'(bus.INT), 32'd0);
        check_value("rst_inserv",  32'(bus.isInterrupted), 32'd0);
        check_value("rst_id",      32'(bus.IrqId), 32'd0);
        check_value("rst_isnmi",   32'(bus.IsNmi), 32'd0);
        check_value("rst_pending", 32'(bus.Pending), 32'd0);
        bus.IrqIn = 8'h20;
        tick();
        check_value("lvl_pend_k",  32'(bus.Pending), 32'h20);
        check_value("lvl_int_k",   32'(bus.INT), 32'd0);
        tick();
        check_value("lvl_int_k1",  32'(bus.INT), 32'd1);
        check_value("lvl_id_k1",   32'(bus.IrqId), 32'd5);
        pulse_ina();
        check_value("lvl_ack_int",    32'(bus.INT), 32'd0);
        check_value("lvl_ack_inserv", 32'(bus.isInterrupted), 32'd1);
        check_value("lvl_ack_pend",   32'(bus.Pending), 32'h20);
        pulse_eoi();
        check_value("lvl_eoi_inserv", 32'(bus.isInterrupted), 32'd0);
        check_value("lvl_eoi_int",    32'(bus.INT), 32'd0);
        tick();
        check_value("lvl_rereq_int", 32'(bus.INT), 32'd1);
        check_value("lvl_rereq_id",  32'(bus.IrqId), 32'd5);

        // ---- 2: priority, mask, INTD
        do_reset();
        bus.IrqIn = 8'h90;
        tick();
        tick();
        check_value("pri_id",  32'(bus.IrqId), 32'd4);
        check_value("pri_int", 32'(bus.INT), 32'd1);
        bus.IrqMask = 8'h10;
        tick();
        check_value("mask_id",  32'(bus.IrqId), 32'd7);
        check_value("mask_int", 32'(bus.INT), 32'd1);
        bus.INTD = 1'b1;
        tick();
        check_value("intd_int", 32'(bus.INT), 32'd0);
        tick();
        check_value("intd_int_hold", 32'(bus.INT), 32'd0);
        check_value("intd_pend",     32'(bus.Pending), 32'h90);

        // ---- 3: NMI pre-empts a pending request in REQ
        do_reset();
        bus.IrqIn = 8'h08;
        tick();
        tick();
        check_value("nmi_pre_id", 32'(bus.IrqId), 32'd3);
        bus.NMI = 1'b1;
        tick();
        bus.NMI = 1'b0;
        tick();
        check_value("nmi_isnmi", 32'(bus.IsNmi), 32'd1);
        check_value("nmi_id",    32'(bus.IrqId), 32'd0);
        check_value("nmi_int",   32'(bus.INT), 32'd1);
        pulse_ina();
        check_value("nmi_svc_inserv", 32'(bus.isInterrupted), 32'd1);
        check_value("nmi_svc_isnmi",  32'(bus.IsNmi), 32'd1);
        check_value("nmi_svc_int",    32'(bus.INT), 32'd0);
        pulse_eoi();
        tick();
        check_value("nmi_after_int",   32'(bus.INT), 32'd1);
        check_value("nmi_after_isnmi", 32'(bus.IsNmi), 32'd0);
        check_value("nmi_after_id",    32'(bus.IrqId), 32'd3);

        // ---- 4: INA and new NMI edge in the same cycle; no nesting
        do_reset();
        bus.IrqIn = 8'h04;
        tick();
        tick();
        check_value("race_id", 32'(bus.IrqId), 32'd2);
        bus.INA = 1'b1;
        bus.NMI = 1'b1;
        tick();
        bus.INA = 1'b0;
        bus.NMI = 1'b0;
        check_value("race_inserv", 32'(bus.isInterrupted), 32'd1);
        check_value("race_isnmi",  32'(bus.IsNmi), 32'd0);
        check_value("race_id_svc", 32'(bus.IrqId), 32'd2);
        tick();
        check_value("race_nonest_int", 32'(bus.INT), 32'd0);
        check_value("race_frozen_id",  32'(bus.IrqId), 32'd2);
        pulse_eoi();
        tick();
        check_value("race_nmi_int",   32'(bus.INT), 32'd1);
        check_value("race_nmi_isnmi", 32'(bus.IsNmi), 32'd1);
        check_value("race_nmi_id",    32'(bus.IrqId), 32'd0);
        pulse_ina();
        pulse_eoi();
        tick();
        check_value("race_back_isnmi", 32'(bus.IsNmi), 32'd0);
        check_value("race_back_id",    32'(bus.IrqId), 32'd2);

        // ---- 5: one-cycle pulse on channel 0, EdgeMode=1
        do_reset();
        bus.EdgeMode = 8'h01;
        bus.IrqIn    = 8'h01;
        tick();
        bus.IrqIn = 8'h00;
        check_value("pulse_pend_k", 32'(bus.Pending), 32'h01);
        tick();
        check_value("pulse_int_k1", 32'(bus.INT), 32'd1);
        check_value("pulse_id_k1",  32'(bus.IrqId), 32'd0);
`ifdef IRQ_EDGE_DETECT_EN
        check_value("pulse_pend_held", 32'(bus.Pending), 32'h01);
        tick();
        check_value("pulse_int_held",  32'(bus.INT), 32'd1);
        pulse_ina();
        check_value("pulse_ack_inserv", 32'(bus.isInterrupted), 32'd1);
        check_value("pulse_ack_pend",   32'(bus.Pending), 32'h00);
        pulse_eoi();
        tick();
        check_value("pulse_no_rereq", 32'(bus.INT), 32'd0);
`else
        check_value("pulse_pend_fall", 32'(bus.Pending), 32'h00);
        tick();
        check_value("pulse_int_drop",  32'(bus.INT), 32'd0);
        check_value("pulse_inserv",    32'(bus.isInterrupted), 32'd0);
`endif

        // ---- 6: ignored INA outside REQ
        do_reset();
        pulse_ina();
        check_value("idle_ina_inserv", 32'(bus.isInterrupted), 32'd0);
        check_value("idle_ina_int",    32'(bus.INT), 32'd0);

        // ---- 7: asynchronous reset mid-SERVICE, line held through release
        do_reset();
        bus.EdgeMode = 8'h02;
        bus.IrqIn    = 8'h08;
        tick();
        tick();
        pulse_ina();
        check_value("pre_rst_inserv", 32'(bus.isInterrupted), 32'd1);
        bus.IrqIn = 8'h02;
        rst_n     = 1'b0;
        #1;
        check_value("arst_inserv",  32'(bus.isInterrupted), 32'd0);
        check_value("arst_int",     32'(bus.INT), 32'd0);
        check_value("arst_id",      32'(bus.IrqId), 32'd0);
        check_value("arst_isnmi",   32'(bus.IsNmi), 32'd0);
        check_value("arst_pending", 32'(bus.Pending), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_value("rel_pend",  32'(bus.Pending), 32'h02);
        check_value("rel_int_k", 32'(bus.INT), 32'd0);
        tick();
        check_value("rel_int", 32'(bus.INT), 32'd1);
        check_value("rel_id",  32'(bus.IrqId), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

- Parametrised interrupt front-end for the multicycle MIPS core.
- Collects `N_IRQ` maskable request lines plus one NMI, holds them pending, and picks a winner by fixed priority.
- Raises a single request to `Controller` and tracks the in-service interrupt until end-of-interrupt.
- Replaces the single INT/NMI pin pair with an acknowledged, identified, per-channel-maskable source.

## Interface
Parameters:
- `N_IRQ`, 8: number of maskable channels, 1..32.
- `ID_W`, 3: width of `IrqId`; must be ≥ ceil(log2(`N_IRQ`)), and ≥1.

Ports (all inputs synchronous to `Clk`):
- `Clk` in 1: single clock; everything updates on the rising edge.
- `Reset_n` in 1: reset is asynchronous and active-low.
- `IrqIn` in `N_IRQ`: request lines; bit 0 is highest priority.
- `EdgeMode` in `N_IRQ`: 1 = rising-edge channel, 0 = level channel (see Configuration).
- `IrqMask` in `N_IRQ`: 1 = channel masked.
- `NMI` in 1: non-maskable request, always rising-edge detected.
- `INTD` in 1: global disable of maskable channels; does not affect NMI.
- `INA` in 1: acknowledge from `Controller`, one-cycle pulse at instruction boundary.
- `EOI` in 1: end-of-interrupt pulse (return-from-interrupt executed).
- `INT` out 1: request to `Controller`.
- `isInterrupted` out 1: an interrupt is in service.
- `IrqId` out `ID_W`: winning/in-service channel index; 0 when `IsNmi`=1.
- `IsNmi` out 1: winner/in-service source is NMI.
- `Pending` out `N_IRQ`: registered pending bits, unmasked view.

## Operation
- Pending logic:
  - Edge channel: the pending bit sets when `IrqIn`=1 and the previous-sample register =0.
  - Edge channel clears only when `INA` acknowledges that channel. Set and clear in the same cycle: set wins.
  - Level channel: the pending bit is the registered `IrqIn`. `INA` does not clear it.
  - NMI: a separate `nmi_pend` latch, set on the `NMI` rising edge and cleared by acknowledge. Set and clear in the same cycle: set wins.
- Eligibility:
  - Maskable set is `Pending & ~IrqMask` when `INTD`=0, else empty.
  - Winner: NMI if `nmi_pend`, otherwise the lowest eligible index.
- FSM states:
  - IDLE: when any candidate exists, register the winner into `IrqId`/`IsNmi` and go to REQ.
  - REQ: `INT`=1. The winner is re-arbitrated and re-registered every cycle, so a new NMI or a higher-priority channel replaces the current winner.
    - If no candidate remains (withdrawn, masked, `INTD` raised), return to IDLE and drop `INT`.
    - On `INA`, acknowledge the registered `IrqId`/`IsNmi` (the value visible that cycle), clear its edge/NMI pending bit, and go to SERVICE.
  - SERVICE: `isInterrupted`=1, `INT`=0, `IrqId`/`IsNmi` frozen.
    - No nesting; new requests, including NMI, stay pending.
    - On `EOI`, return to IDLE.
- Ignored events: `INA` outside REQ; `EOI` outside SERVICE.
- A level channel still high after `EOI` is requested again.
- Reset (async, any state, including mid-REQ or SERVICE):
  - State → IDLE.
  - `INT`, `isInterrupted`, `IsNmi`, `IrqId`, `Pending`, `nmi_pend` → 0.
  - Previous-sample registers → 0, so a line already high at reset release counts as an edge.

## Timing
- `IrqIn`/`NMI` sampled at edge k sets pending after edge k. `INT` and a valid `IrqId` follow after edge k+1. Request latency is 2 cycles.
- `INA` at edge j: after edge j, `INT`=0, `isInterrupted`=1, and the pending bit is cleared.
- `EOI` at edge j: after edge j the block is in IDLE. A still-pending request re-raises `INT` after edge j+1.
- Mask or `INTD` change at edge j takes effect on eligibility in the same evaluation. The state is in IDLE after edge j if nothing else remains.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined:
  - Per-channel edge/level selection via `EdgeMode`.
  - Previous-sample registers exist for every channel.
- Not defined:
  - All maskable channels are level-sensitive.
  - `EdgeMode` is ignored and its per-channel edge registers are removed.
  - NMI remains edge-detected in both builds.

## Test plan
- Reset release, `N_IRQ`=8, all inputs 0 → all outputs 0. Then `IrqIn`=8'h20 (level) → `INT`=1 two cycles later, `IrqId`=5; `INA` → `isInterrupted`=1, `INT`=0; `EOI` with line still high → `INT`=1 again.
- `IrqIn`=8'h90 unmasked → `IrqId`=4. Then `IrqMask`=8'h10 → `IrqId`=7. Then `INTD`=1 → `INT` drops and the FSM returns to IDLE.
- In REQ with `IrqId`=3, pulse `NMI` → `IsNmi`=1, `IrqId`=0. `INA` → NMI in service and `nmi_pend`=0; channel 3 stays pending and is served after `EOI`.
- `INA` and a new `NMI` edge in the same cycle while a maskable winner (`IrqId`=2) is shown → channel 2 enters service and `nmi_pend`=1. After `EOI`, `IsNmi`=1.
- With `IRQ_EDGE_DETECT_EN`, `EdgeMode`=8'h01: 1-cycle pulse on `IrqIn[0]` → pending held until `INA`, then cleared. The same pulse without the macro → `INT` drops when the line falls, before any `INA`.
- Assert `Reset_n`=0 mid-SERVICE → all outputs 0 immediately (asynchronous). `IrqIn[1]` held high through release in edge mode → `INT` after 2 cycles.
